// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
// Optional parity generation is enabled by defining UART_TX_ARB_PARITY_EN.
`timescale 1ns / 1ps

module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                 baud_clk,
  input  logic                 arst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic                 cfg_data_length,
  input  logic                 cfg_stop_bits,
  input  logic [1:0]           cfg_parity_type,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  output logic                 tx_parity,
  output logic                 tx_data_length,
  output logic                 tx_stop_bits,
  output logic [1:0]           tx_parity_type,
  output logic                 busy,
  output logic [2:0]           last_gnt,
  output logic                 err
);

  typedef enum logic [1:0] {StIdle, StSend, StWaitDone} state_e;

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [3:0] tcnt_q;

  logic [7:0]  req_ext;
  logic [63:0] data_ext;
  logic [3:0]  idx_sum;
  logic [2:0]  win_idx;
  logic        win_valid;
  logic [7:0]  win_data;
  logic        par_bit;
  logic [1:0]  ptype_in;

  // Scan from ptr upward with wrap; descending loop so the smallest offset wins.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    data_ext               = '0;
    data_ext[8*NUM_REQ-1:0] = req_data;
    win_valid              = 1'b0;
    win_idx                = '0;
    idx_sum                = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_sum = 4'(ptr_q) + 4'(i);
      if (idx_sum >= 4'(NUM_REQ)) idx_sum = idx_sum - 4'(NUM_REQ);
      if (req_ext[idx_sum[2:0]]) begin
        win_valid = 1'b1;
        win_idx   = idx_sum[2:0];
      end
    end
  end

  assign win_data = data_ext[{win_idx, 3'b000} +: 8];

`ifdef UART_TX_ARB_PARITY_EN
  logic par_xor;

  always_comb begin
    par_xor  = cfg_data_length ? ^win_data : ^win_data[6:0];
    ptype_in = cfg_parity_type;
    case (cfg_parity_type)
      2'b10:   par_bit = par_xor;
      2'b01:   par_bit = ~par_xor;
      default: par_bit = 1'b0;
    endcase
  end
`else
  logic unused_parity_type;

  assign unused_parity_type = ^cfg_parity_type;
  assign par_bit            = 1'b0;
  assign ptype_in           = 2'b00;
`endif

  assign busy = (state_q != StIdle);

  always_ff @(posedge baud_clk or posedge arst) begin
    if (arst) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      tcnt_q         <= '0;
      last_gnt       <= '0;
      gnt            <= '0;
      tx_send        <= 1'b0;
      tx_data        <= '0;
      tx_parity      <= 1'b0;
      tx_data_length <= 1'b0;
      tx_stop_bits   <= 1'b0;
      tx_parity_type <= '0;
      err            <= 1'b0;
    end else begin
      gnt <= '0;
      err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_valid && tx_done) begin
            tx_data        <= win_data;
            tx_data_length <= cfg_data_length;
            tx_stop_bits   <= cfg_stop_bits;
            tx_parity_type <= ptype_in;
            tx_parity      <= par_bit;
            gnt            <= NUM_REQ'(1) << win_idx;
            last_gnt       <= win_idx;
            ptr_q          <= (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
            tx_send        <= 1'b1;
            tcnt_q         <= '0;
            state_q        <= StSend;
          end
        end
        StSend: begin
          if (tx_active) begin
            tx_send <= 1'b0;
            state_q <= StWaitDone;
          end else if (tcnt_q == 4'(TIMEOUT - 1)) begin
            // Transmitter never started: drop the byte.
            err     <= 1'b1;
            tx_send <= 1'b0;
            state_q <= StIdle;
          end else begin
            tcnt_q <= tcnt_q + 4'd1;
          end
        end
        StWaitDone: begin
          if (tx_done && !tx_active) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: grants are queued as expected and checked by a monitor.
`timescale 1ns / 1ps

module tb_uart_tx_arbiter;

  logic        baud_clk;
  logic        arst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        cfg_data_length;
  logic        cfg_stop_bits;
  logic [1:0]  cfg_parity_type;
  logic        tx_active;
  logic        tx_done;
  logic [3:0]  gnt;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_parity;
  logic        tx_data_length;
  logic        tx_stop_bits;
  logic [1:0]  tx_parity_type;
  logic        busy;
  logic [2:0]  last_gnt;
  logic        err;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .TIMEOUT(8)
  ) dut (
    .baud_clk       (baud_clk),
    .arst           (arst),
    .req            (req),
    .req_data       (req_data),
    .cfg_data_length(cfg_data_length),
    .cfg_stop_bits  (cfg_stop_bits),
    .cfg_parity_type(cfg_parity_type),
    .tx_active      (tx_active),
    .tx_done        (tx_done),
    .gnt            (gnt),
    .tx_send        (tx_send),
    .tx_data        (tx_data),
    .tx_parity      (tx_parity),
    .tx_data_length (tx_data_length),
    .tx_stop_bits   (tx_stop_bits),
    .tx_parity_type (tx_parity_type),
    .busy           (busy),
    .last_gnt       (last_gnt),
    .err            (err)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] data;
    logic [2:0] idx;
    logic       len;
    logic       stop;
    logic [1:0] ptype;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  logic prev_gnt = 1'b0;

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge baud_clk);
    #1;
  endtask

  // Parity and parity type in the vectors assume the parity build; masked otherwise.
  task automatic grant(input logic [3:0] g, input logic [7:0] d, input logic [2:0] idx,
                       input logic len, input logic stop, input logic [1:0] pt,
                       input logic par);
    exp_t e;
    e.gnt  = g;
    e.data = d;
    e.idx  = idx;
    e.len  = len;
    e.stop = stop;
`ifdef UART_TX_ARB_PARITY_EN
    e.ptype = pt;
    e.par   = par;
`else
    e.ptype = 2'b00;
    e.par   = 1'b0 & par;
`endif
    exp_q.push_back(e);
    step();
    chk("grant_tx_send", tx_send, 1);
    chk("grant_busy", busy, 1);
  endtask

  task automatic frame(input int send_wait);
    repeat (send_wait) begin
      step();
      chk("tx_send_held", tx_send, 1);
    end
    tx_active = 1'b1;
    tx_done   = 1'b0;
    step();
    chk("tx_send_fall", tx_send, 0);
    chk("busy_wait", busy, 1);
    step();
    tx_active = 1'b0;
    tx_done   = 1'b1;
    step();
    chk("busy_idle", busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_tx_send"}, tx_send, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_parity"}, tx_parity, 0);
    chk({tag, "_tx_len"}, tx_data_length, 0);
    chk({tag, "_tx_stop"}, tx_stop_bits, 0);
    chk({tag, "_tx_ptype"}, tx_parity_type, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_last_gnt"}, last_gnt, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Monitor: every grant pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge baud_clk);
      if (prev_gnt) chk("gnt_one_cycle", gnt, 0);
      if (gnt !== 4'b0000) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_grant: got %0h expected none at %0t", gnt, $time);
        end else begin
          e = exp_q.pop_front();
          chk("mon_gnt", gnt, e.gnt);
          chk("mon_tx_data", tx_data, e.data);
          chk("mon_last_gnt", last_gnt, e.idx);
          chk("mon_tx_len", tx_data_length, e.len);
          chk("mon_tx_stop", tx_stop_bits, e.stop);
          chk("mon_tx_ptype", tx_parity_type, e.ptype);
          chk("mon_tx_parity", tx_parity, e.par);
          chk("mon_tx_send", tx_send, 1);
        end
      end
      prev_gnt = (gnt !== 4'b0000);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst            = 1'b1;
    req             = '0;
    req_data        = '0;
    cfg_data_length = 1'b0;
    cfg_stop_bits   = 1'b0;
    cfg_parity_type = 2'b00;
    tx_active       = 1'b0;
    tx_done         = 1'b0;
    @(negedge baud_clk);
    chk_all_zero("reset");
    step();
    arst = 1'b0;

    // Single request
    req             = 4'b0001;
    req_data        = 32'h0000_0075;
    cfg_data_length = 1'b1;
    cfg_stop_bits   = 1'b0;
    cfg_parity_type = 2'b10;
    tx_done         = 1'b1;
    grant(4'b0001, 8'h75, 3'd0, 1'b1, 1'b0, 2'b10, 1'b1);
    req = 4'b0000;
    frame(1);

    // Round-robin from a freshly reset pointer
    arst = 1'b1;
    step();
    arst            = 1'b0;
    req_data        = 32'hA3A2_A1A0;
    req             = 4'b1111;
    cfg_stop_bits   = 1'b1;
    cfg_parity_type = 2'b00;
    for (int k = 0; k < 5; k++) begin
      grant(4'(1 << (k % 4)), 8'hA0 + 8'(k % 4), 3'(k % 4), 1'b1, 1'b1, 2'b00, 1'b0);
      if (k == 4) req = 4'b0000;
      frame(0);
    end

    // Parity vectors
    req_data        = 32'h0000_0075;
    cfg_parity_type = 2'b10;
    req             = 4'b0001;
    grant(4'b0001, 8'h75, 3'd0, 1'b1, 1'b1, 2'b10, 1'b1);
    req = 4'b0000;
    frame(0);
    cfg_parity_type = 2'b01;
    req             = 4'b0001;
    grant(4'b0001, 8'h75, 3'd0, 1'b1, 1'b1, 2'b01, 1'b0);
    req = 4'b0000;
    frame(0);
    req_data        = 32'h0000_00F5;
    cfg_data_length = 1'b0;
    cfg_parity_type = 2'b10;
    req             = 4'b0001;
    grant(4'b0001, 8'hF5, 3'd0, 1'b0, 1'b1, 2'b10, 1'b1);
    req = 4'b0000;
    frame(0);

    // Start timeout on requester 2
    req_data        = 32'h003C_0000;
    cfg_data_length = 1'b1;
    req             = 4'b0100;
    grant(4'b0100, 8'h3C, 3'd2, 1'b1, 1'b1, 2'b10, 1'b0);
    req = 4'b0000;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("err_timing", err, (c == 8) ? 1 : 0);
    end
    chk("timeout_tx_send", tx_send, 0);
    chk("timeout_busy", busy, 0);
    step();
    chk("err_one_cycle", err, 0);

    // Pointer now at 3; config frozen during WAIT_DONE
    req_data      = 32'h5A00_0011;
    cfg_stop_bits = 1'b0;
    req           = 4'b1011;
    grant(4'b1000, 8'h5A, 3'd3, 1'b1, 1'b0, 2'b10, 1'b0);
    req       = 4'b0000;
    tx_active = 1'b1;
    tx_done   = 1'b0;
    step();
    cfg_stop_bits   = 1'b1;
    cfg_data_length = 1'b0;
    step();
    chk("freeze_stop", tx_stop_bits, 0);
    chk("freeze_len", tx_data_length, 1);
    chk("freeze_data", tx_data, 8'h5A);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    step();
    chk("freeze_idle", busy, 0);

    // tx_done gating in IDLE
    tx_done  = 1'b0;
    req_data = 32'h0000_00C3;
    req      = 4'b0001;
    repeat (3) begin
      step();
      chk("gate_gnt", gnt, 0);
      chk("gate_busy", busy, 0);
    end
    tx_done = 1'b1;
    grant(4'b0001, 8'hC3, 3'd0, 1'b0, 1'b1, 2'b10, 1'b1);
    req       = 4'b0000;
    tx_active = 1'b1;
    tx_done   = 1'b0;
    step();
    chk("mid_busy", busy, 1);

    // Reset in WAIT_DONE
    #2;
    arst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge baud_clk);
    chk("midrst_err", err, 0);
    step();
    arst      = 1'b0;
    tx_active = 1'b0;
    tx_done   = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_gnt", gnt, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
